// File: rtl/press_pkg.sv
// press_pkg: shared FSM encoding, timing defaults and helpers for the press classifier
package press_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;
  localparam logic [19:0] DEF_DEB_CYCLES    = 20'd1000000;
  localparam logic [26:0] DEF_LONG_CYCLES   = 27'd100000000;
  localparam logic [24:0] DEF_REPEAT_CYCLES = 25'd20000000;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/press_channel.sv
// press_channel: one button's synchroniser, debouncer and short/long/repeat classifier
module press_channel
  import press_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter logic [26:0] LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic [24:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn_in,
  output logic btn_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = max_int($clog2(LONG_CYCLES), $clog2(REPEAT_CYCLES));
  localparam logic [DW-1:0] DEB_TOP  = DW'(DEB_CYCLES - 1'b1);
  localparam logic [HW-1:0] LONG_TOP = HW'(LONG_CYCLES - 1'b1);
  localparam logic [HW-1:0] REP_TOP  = HW'(REPEAT_CYCLES - 1'b1);
  state_t state_q, state_d;
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic level_q, level_d, prev_q, prev_d, armed_q, armed_d;
  logic short_q, short_d, long_q, long_d, rep_q, rep_d;
  logic [1:0] vld_q, vld_d;
  logic [DW-1:0] db_q, db_d;
  logic [HW-1:0] hold_q, hold_d;
  logic diff, toggle, rise;
  assign diff   = sync2_q ^ level_q;
  assign toggle = diff & (db_q == DEB_TOP);
  assign rise   = level_q & ~prev_q;
  // armed only once a real released level has come through the synchroniser,
  // so a button held across reset never starts a press
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    db_d    = (diff && !toggle) ? db_q + 1'b1 : '0;
    level_d = level_q ^ toggle;
    prev_d  = level_q;
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
    state_d = state_q;
    hold_d  = hold_q + 1'b1;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          hold_d = '0;
          if (rise && armed_q) state_d = ST_HELD;
        end
        ST_HELD: begin
          if (!level_q) begin
            short_d = 1'b1;
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == LONG_TOP) begin
            long_d  = 1'b1;
            state_d = ST_LONG;
            hold_d  = '0;
          end
        end
        ST_LONG: begin
          if (!level_q) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == REP_TOP) begin
            rep_d  = REPEAT_EN;
            hold_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= '0;
      db_q    <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      db_q    <= db_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end
  assign btn_level    = level_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign busy         = (state_q != ST_IDLE);
endmodule

// File: rtl/press_classifier.sv
// press_classifier: NUM_CH independent debounced short/long/repeat button classifiers
module press_classifier
  import press_pkg::*;
#(
  parameter int          NUM_CH        = 4,
  parameter logic [19:0] DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter logic [26:0] LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic [24:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] short_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic [NUM_CH-1:0] busy
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    press_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .short_pulse (short_pulse[i]),
      .long_pulse  (long_pulse[i]),
      .repeat_pulse(repeat_pulse[i]),
      .busy        (busy[i])
    );
  end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: timestamp model plus directed press scenarios for two classifier builds
module tb_press_classifier;
  localparam int NCH = 2, DEB = 4, LONG = 20, REP = 8, MAXN = 2048;
  logic clk, rst_n, en;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] a_level, a_short, a_long, a_rep, a_busy;
  logic [NCH-1:0] b_level, b_short, b_long, b_rep, b_busy;
  int checks = 0, failures = 0;

  press_classifier #(.NUM_CH(NCH), .DEB_CYCLES(20'd4), .LONG_CYCLES(27'd20),
    .REPEAT_CYCLES(25'd8), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .btn_in(btn_in), .btn_level(a_level),
    .short_pulse(a_short), .long_pulse(a_long), .repeat_pulse(a_rep), .busy(a_busy));
  press_classifier #(.NUM_CH(NCH), .DEB_CYCLES(20'd4), .LONG_CYCLES(27'd20),
    .REPEAT_CYCLES(25'd8), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .btn_in(btn_in), .btn_level(b_level),
    .short_pulse(b_short), .long_pulse(b_long), .repeat_pulse(b_rep), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edge index n since reset, raw/sync history per channel, press start timestamps
  int n;
  bit hist[NCH][MAXN];
  bit synch[NCH][MAXN];
  bit lvl[NCH], armed[NCH];
  int rise_t[NCH];
  bit active[2][NCH];
  int press_t[2][NCH];
  bit e_short[2][NCH], e_long[2][NCH], e_rep[2][NCH], e_busy[2][NCH];

  always @(posedge clk or negedge rst_n) begin
    bit s, lnew, all_diff, arm_b;
    int e;
    if (!rst_n) begin
      n = 0;
      for (int c = 0; c < NCH; c++) begin
        lvl[c] = 1'b0;
        armed[c] = 1'b0;
        rise_t[c] = -10;
        for (int i = 0; i < 2; i++) begin
          active[i][c] = 1'b0;
          e_short[i][c] = 1'b0;
          e_long[i][c] = 1'b0;
          e_rep[i][c] = 1'b0;
          e_busy[i][c] = 1'b0;
        end
      end
    end else if (n < MAXN - 1) begin
      n++;
      for (int c = 0; c < NCH; c++) begin
        hist[c][n] = btn_in[c];
        s = (n >= 3) ? hist[c][n-2] : 1'b0;
        synch[c][n] = s;
        all_diff = (n >= DEB);
        for (int j = n - DEB + 1; j <= n; j++)
          if (j >= 1 && synch[c][j] == lvl[c]) all_diff = 1'b0;
        lnew = all_diff ? ~lvl[c] : lvl[c];
        arm_b = armed[c];
        for (int i = 0; i < 2; i++) begin
          e_short[i][c] = 1'b0;
          e_long[i][c] = 1'b0;
          e_rep[i][c] = 1'b0;
          if (active[i][c]) begin
            e = n - press_t[i][c];
            if (!en) active[i][c] = 1'b0;
            else if (!lvl[c]) begin
              active[i][c] = 1'b0;
              e_short[i][c] = (e - 1 < LONG);
            end else begin
              e_long[i][c] = (e == LONG);
              e_rep[i][c] = (i == 0) && (e > LONG) && ((e - LONG) % REP == 0);
            end
          end else if (en && arm_b && rise_t[c] == n - 1) begin
            active[i][c] = 1'b1;
            press_t[i][c] = n;
          end
          e_busy[i][c] = active[i][c];
        end
        if (n >= 3 && !hist[c][n-2]) armed[c] = 1'b1;
        if (lnew && !lvl[c]) rise_t[c] = n;
        lvl[c] = lnew;
      end
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] el, es, elg, er, eb;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NCH; c++) begin
        el[c] = lvl[c];
        es[c] = e_short[i][c];
        elg[c] = e_long[i][c];
        er[c] = e_rep[i][c];
        eb[c] = e_busy[i][c];
      end
      chk(i == 0 ? "a_level" : "b_level", i == 0 ? a_level : b_level, el);
      chk(i == 0 ? "a_short" : "b_short", i == 0 ? a_short : b_short, es);
      chk(i == 0 ? "a_long" : "b_long", i == 0 ? a_long : b_long, elg);
      chk(i == 0 ? "a_repeat" : "b_repeat", i == 0 ? a_rep : b_rep, er);
      chk(i == 0 ? "a_busy" : "b_busy", i == 0 ? a_busy : b_busy, eb);
    end
  end

  int ns[NCH], nl[NCH], nr[NCH], nrb, nhi1;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      ns[c] += int'(a_short[c]);
      nl[c] += int'(a_long[c]);
      nr[c] += int'(a_rep[c]);
    end
    nrb += int'(|b_rep);
    nhi1 += int'(a_level[1] | a_busy[1] | a_short[1] | a_long[1] | a_rep[1]);
  end

  task automatic clr();
    for (int c = 0; c < NCH; c++) begin
      ns[c] = 0;
      nl[c] = 0;
      nr[c] = 0;
    end
    nrb = 0;
    nhi1 = 0;
  endtask

  function automatic logic sel(input int kind, input int c);
    case (kind)
      0: return a_level[c];
      1: return ~a_level[c];
      2: return a_short[c];
      default: return a_long[c];
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int c, output int k);
    k = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sel(kind, c)) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    en = 1'b1;
    btn_in = '0;
    clr();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a_level, a_short, a_long, a_rep, a_busy}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // short press of 10 cycles on channel 0
    clr();
    btn_in[0] = 1'b1;
    wait_ev(0, 0, k);
    chk("t1_rise_latency", k, 6);
    repeat (4) @(negedge clk);
    btn_in[0] = 1'b0;
    wait_ev(1, 0, k);
    chk("t1_fall_latency", k, 6);
    wait_ev(2, 0, k);
    chk("t1_short_delay", k, 1);
    repeat (3) @(negedge clk);
    chk("t1_short_count", ns[0], 1);
    chk("t1_long_count", nl[0], 0);
    // 3-cycle glitch on channel 1
    clr();
    btn_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t2_glitch_activity", nhi1, 0);
    // 60-cycle hold: one long, four repeats, no short
    clr();
    btn_in[0] = 1'b1;
    wait_ev(0, 0, k);
    wait_ev(3, 0, k);
    chk("t3_long_after_rise", k, 21);
    repeat (33) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t3_long_count", nl[0], 1);
    chk("t3_repeat_count", nr[0], 4);
    chk("t3_short_count", ns[0], 0);
    chk("t3_norepeat_build", nrb, 0);
    // fall lands on the last HELD cycle -> short only; one cycle later -> long
    clr();
    btn_in[0] = 1'b1;
    repeat (20) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_edge_short", ns[0], 1);
    chk("t4_edge_long", nl[0], 0);
    clr();
    btn_in[0] = 1'b1;
    repeat (21) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t4_over_long", nl[0], 1);
    chk("t4_over_short", ns[0], 0);
    chk("t4_over_repeat", nr[0], 0);
    // both channels, offset by 5 cycles
    clr();
    btn_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    btn_in[1] = 1'b1;
    repeat (40) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    btn_in[1] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_long_ch0", nl[0], 1);
    chk("t5_long_ch1", nl[1], 1);
    chk("t5_rep_ch0", nr[0], 3);
    chk("t5_rep_ch1", nr[1], 3);
    chk("t5_norepeat_build", nrb, 0);
    // reset in the middle of LONG with the button kept held
    btn_in[0] = 1'b1;
    repeat (35) @(negedge clk);
    chk("t6_busy_before_reset", a_busy[0], 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", {a_level, a_short, a_long, a_rep, a_busy}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    repeat (60) @(negedge clk);
    chk("t6_level_after_reset", a_level[0], 1);
    chk("t6_no_press_after_reset", ns[0] + nl[0] + nr[0] + int'(a_busy[0]), 0);
    btn_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    btn_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_repress_short", ns[0], 1);
    // enable dropped mid-hold, then restored with the level still high
    clr();
    btn_in[0] = 1'b1;
    wait_ev(0, 0, k);
    chk("t7_rise_latency", k, 6);
    repeat (3) @(negedge clk);
    chk("t7_busy_held", a_busy[0], 1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t7_busy_en_low", a_busy[0], 0);
    repeat (30) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    chk("t7_no_restart", a_busy[0], 0);
    btn_in[0] = 1'b0;
    repeat (15) @(negedge clk);
    chk("t7_no_pulses", ns[0] + nl[0] + nr[0], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
